// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared defaults, dequeue FSM encoding and helpers for pifo_req_sched
// Contents: default parameter values, deq_state_e, ptr_width() for round-robin pointers.
package pifo_pkg;

  localparam int PIFO_DEF_NUM_PORTS     = 4;
  localparam int PIFO_DEF_RANK_WIDTH    = 10;
  localparam int PIFO_DEF_META_WIDTH    = 20;
  localparam int PIFO_DEF_MAX_ENTRIES   = 32;
  localparam int PIFO_DEF_SETTLE_CYCLES = 2;

  // Wide enough for SETTLE_CYCLES up to 15.
  localparam int PIFO_SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    DQ_IDLE   = 2'd0,
    DQ_REMOVE = 2'd1,
    DQ_SETTLE = 2'd2
  } deq_state_e;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant: first requester at or after ptr, wrapping
// Ports: req_i (per-port request), ptr_i (search start), grant_o (one-hot),
//        grant_idx_o (index of grant_o), grant_any_o (some request granted).
module rr_arbiter
  import pifo_pkg::*;
#(
  parameter int NUM_PORTS = PIFO_DEF_NUM_PORTS,
  parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [PTR_W-1:0]     grant_idx_o,
  output logic                 grant_any_o
);

  localparam int              SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] N_W  = SUM_W'(NUM_PORTS);

  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // ptr_i and i are both below NUM_PORTS, so one subtraction wraps.
      sum = {1'b0, ptr_i} + SUM_W'(i);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/pifo_req_sched.sv
// rtl/pifo_req_sched.sv - multi-port round-robin enqueue and paced dequeue front-end for a PIFO
// Ports: enq_valid/enq_ready/enq_rank/enq_meta (per-port insert requests),
//        deq_req/deq_valid/deq_rank/deq_meta/deq_empty (dequeue side),
//        pifo_insert/pifo_rank_in/pifo_meta_in/pifo_remove (commands to PIFO),
//        pifo_busy/pifo_valid_out/pifo_rank_out/pifo_meta_out (PIFO status/head),
//        occupancy (entries currently held).
module pifo_req_sched
  import pifo_pkg::*;
#(
  parameter int NUM_PORTS     = PIFO_DEF_NUM_PORTS,
  parameter int RANK_WIDTH    = PIFO_DEF_RANK_WIDTH,
  parameter int META_WIDTH    = PIFO_DEF_META_WIDTH,
  parameter int MAX_ENTRIES   = PIFO_DEF_MAX_ENTRIES,
  parameter int SETTLE_CYCLES = PIFO_DEF_SETTLE_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            enq_valid,
  output logic [NUM_PORTS-1:0]            enq_ready,
  input  logic [NUM_PORTS*RANK_WIDTH-1:0] enq_rank,
  input  logic [NUM_PORTS*META_WIDTH-1:0] enq_meta,
  input  logic                            deq_req,
  output logic                            deq_valid,
  output logic [RANK_WIDTH-1:0]           deq_rank,
  output logic [META_WIDTH-1:0]           deq_meta,
  output logic                            deq_empty,
  output logic                            pifo_insert,
  output logic [RANK_WIDTH-1:0]           pifo_rank_in,
  output logic [META_WIDTH-1:0]           pifo_meta_in,
  output logic                            pifo_remove,
  input  logic                            pifo_busy,
  input  logic                            pifo_valid_out,
  input  logic [RANK_WIDTH-1:0]           pifo_rank_out,
  input  logic [META_WIDTH-1:0]           pifo_meta_out,
  output logic [$clog2(MAX_ENTRIES):0]    occupancy
);

  localparam int                          OCC_W     = $clog2(MAX_ENTRIES) + 1;
  localparam int                          PTR_W     = ptr_width(NUM_PORTS);
  localparam logic [OCC_W-1:0]            MAX_OCC   = OCC_W'(MAX_ENTRIES);
  localparam logic [PTR_W-1:0]            LAST_PORT = PTR_W'(NUM_PORTS - 1);
  localparam logic [PIFO_SETTLE_CNT_W-1:0] SETTLE_LAST =
    PIFO_SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  deq_state_e                   state_q, state_d;
  logic [PIFO_SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_next;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic                         ins_q;
  logic [RANK_WIDTH-1:0]        ins_rank_q, sel_rank;
  logic [META_WIDTH-1:0]        ins_meta_q, sel_meta;
  logic [RANK_WIDTH-1:0]        deq_rank_q;
  logic [META_WIDTH-1:0]        deq_meta_q;
  logic                         deq_empty_q;

  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 remove_now, can_insert, accept, in_idle;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req_i       (enq_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign in_idle    = (state_q == DQ_IDLE);
  assign remove_now = in_idle & deq_req & pifo_valid_out & (occ_q != '0);
  // A remove this cycle blocks insert acceptance so the PIFO never sees both.
  assign can_insert = ~pifo_busy & (occ_q < MAX_OCC) & ~remove_now;
  // rst_n gates the combinational ready so it drops the instant reset asserts.
  assign enq_ready  = (rst_n & can_insert) ? grant : '0;
  assign accept     = rst_n & can_insert & grant_any;
  assign rr_next    = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_rank = '0;
    sel_meta = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) begin
        sel_rank = enq_rank[k*RANK_WIDTH +: RANK_WIDTH];
        sel_meta = enq_meta[k*META_WIDTH +: META_WIDTH];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && (occ_q != MAX_OCC)) begin
      occ_d = occ_q + 1'b1;
    end else if (remove_now && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    deq_valid    = 1'b0;
    pifo_remove  = 1'b0;
    case (state_q)
      DQ_IDLE: begin
        if (remove_now) begin
          state_d = DQ_REMOVE;
        end
      end
      DQ_REMOVE: begin
        deq_valid    = 1'b1;
        pifo_remove  = 1'b1;
        state_d      = DQ_SETTLE;
        settle_cnt_d = SETTLE_LAST;
      end
      DQ_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = DQ_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = DQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DQ_IDLE;
      settle_cnt_q <= '0;
      rr_ptr_q     <= '0;
      occ_q        <= '0;
      ins_q        <= 1'b0;
      ins_rank_q   <= '0;
      ins_meta_q   <= '0;
      deq_rank_q   <= '0;
      deq_meta_q   <= '0;
      deq_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      occ_q        <= occ_d;
      ins_q        <= accept;
      ins_rank_q   <= accept ? sel_rank : '0;
      ins_meta_q   <= accept ? sel_meta : '0;
      if (accept) begin
        rr_ptr_q <= rr_next;
      end
      if (remove_now) begin
        deq_rank_q <= pifo_rank_out;
        deq_meta_q <= pifo_meta_out;
      end
      deq_empty_q <= in_idle & deq_req & ~remove_now;
    end
  end

  assign pifo_insert  = ins_q;
  assign pifo_rank_in = ins_rank_q;
  assign pifo_meta_in = ins_meta_q;
  assign deq_rank     = deq_rank_q;
  assign deq_meta     = deq_meta_q;
  assign deq_empty    = deq_empty_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_pifo_req_sched.sv
// tb/tb_pifo_req_sched.sv - directed scoreboard bench for pifo_req_sched
module tb_pifo_req_sched;

  localparam int NP = 4;
  localparam int RW = 10;
  localparam int MW = 20;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   enq_valid;
  logic [NP-1:0]   enq_ready;
  logic [NP*RW-1:0] enq_rank;
  logic [NP*MW-1:0] enq_meta;
  logic            deq_req;
  logic            deq_valid;
  logic [RW-1:0]   deq_rank;
  logic [MW-1:0]   deq_meta;
  logic            deq_empty;
  logic            pifo_insert;
  logic [RW-1:0]   pifo_rank_in;
  logic [MW-1:0]   pifo_meta_in;
  logic            pifo_remove;
  logic            pifo_busy;
  logic            pifo_valid_out;
  logic [RW-1:0]   pifo_rank_out;
  logic [MW-1:0]   pifo_meta_out;
  logic [5:0]      occupancy;

  pifo_req_sched #(
    .NUM_PORTS     (NP),
    .RANK_WIDTH    (RW),
    .META_WIDTH    (MW),
    .MAX_ENTRIES   (32),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_rank       (enq_rank),
    .enq_meta       (enq_meta),
    .deq_req        (deq_req),
    .deq_valid      (deq_valid),
    .deq_rank       (deq_rank),
    .deq_meta       (deq_meta),
    .deq_empty      (deq_empty),
    .pifo_insert    (pifo_insert),
    .pifo_rank_in   (pifo_rank_in),
    .pifo_meta_in   (pifo_meta_in),
    .pifo_remove    (pifo_remove),
    .pifo_busy      (pifo_busy),
    .pifo_valid_out (pifo_valid_out),
    .pifo_rank_out  (pifo_rank_out),
    .pifo_meta_out  (pifo_meta_out),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ins_cnt = 0;
  int rem_cnt = 0;
  int emp_cnt = 0;
  int base_ins, base_rem, base_emp;

  logic [RW+MW-1:0] sb_ins[$];
  logic [RW+MW-1:0] sb_deq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [RW-1:0] r, input logic [MW-1:0] m);
    enq_rank[k*RW +: RW] = r;
    enq_meta[k*MW +: MW] = m;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_enq_ready"}, 64'(enq_ready), 64'(0));
    chk({tag, "_insert"},    64'(pifo_insert), 64'(0));
    chk({tag, "_remove"},    64'(pifo_remove), 64'(0));
    chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(0));
    chk({tag, "_deq_empty"}, 64'(deq_empty), 64'(0));
    chk({tag, "_deq_data"},  64'({deq_rank, deq_meta}), 64'(0));
    chk({tag, "_ins_data"},  64'({pifo_rank_in, pifo_meta_in}), 64'(0));
    chk({tag, "_occ"},       64'(occupancy), 64'(0));
  endtask

  // Scoreboard side: every insert/remove pulse pops the oldest expectation.
  always @(negedge clk) begin : mon
    logic [RW+MW-1:0] e;
    if (rst_n) begin
      chk("ins_rem_excl", 64'(pifo_insert & pifo_remove), 64'(0));
      if (pifo_insert) begin
        ins_cnt++;
        checks++;
        assert (sb_ins.size() != 0) else begin
          errors++;
          $error("FAIL ins_unexpected: observed insert %0h expected none", {pifo_rank_in, pifo_meta_in});
        end
        if (sb_ins.size() != 0) begin
          e = sb_ins.pop_front();
          chk("ins_data", 64'({pifo_rank_in, pifo_meta_in}), 64'(e));
        end
      end else begin
        chk("ins_idle_zero", 64'({pifo_rank_in, pifo_meta_in}), 64'(0));
      end
      if (pifo_remove) begin
        rem_cnt++;
        chk("deq_valid_with_remove", 64'(deq_valid), 64'(1));
        checks++;
        assert (sb_deq.size() != 0) else begin
          errors++;
          $error("FAIL deq_unexpected: observed dequeue %0h expected none", {deq_rank, deq_meta});
        end
        if (sb_deq.size() != 0) begin
          e = sb_deq.pop_front();
          chk("deq_data", 64'({deq_rank, deq_meta}), 64'(e));
        end
      end else begin
        chk("deq_valid_idle", 64'(deq_valid), 64'(0));
      end
      if (deq_empty) emp_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    enq_valid = '1;
    enq_rank = '0;
    enq_meta = '0;
    deq_req = 1'b0;
    pifo_busy = 1'b0;
    pifo_valid_out = 1'b0;
    pifo_rank_out = '0;
    pifo_meta_out = '0;
    #12;
    chk_reset_outs("rst0");
    tick();
    rst_n = 1'b1;
    enq_valid = '0;

    // Dequeue with nothing held: refused with deq_empty, never a remove.
    base_emp = emp_cnt;
    base_rem = rem_cnt;
    deq_req = 1'b1;
    @(negedge clk);
    chk("c_empty_latency", 64'(deq_empty), 64'(0));
    tick();
    pifo_valid_out = 1'b1;
    @(negedge clk);
    chk("c_empty1", 64'(deq_empty), 64'(1));
    tick();
    deq_req = 1'b0;
    pifo_valid_out = 1'b0;
    @(negedge clk);
    chk("c_empty2_head_valid_occ0", 64'(deq_empty), 64'(1));
    tick();
    @(negedge clk);
    chk("c_empty_clear", 64'(deq_empty), 64'(0));
    tick();
    chk("c_empty_pulses", 64'(emp_cnt - base_emp), 64'(2));
    chk("c_no_remove", 64'(rem_cnt - base_rem), 64'(0));

    // Ports 0 and 2 valid from rr_ptr 0.
    base_ins = ins_cnt;
    set_port(0, 10'd11, 20'h11111);
    set_port(2, 10'd22, 20'h22222);
    enq_valid = 4'b0101;
    sb_ins.push_back({10'd11, 20'h11111});
    sb_ins.push_back({10'd22, 20'h22222});
    @(negedge clk);
    chk("a_grant_p0", 64'(enq_ready), 64'(4'b0001));
    tick();
    enq_valid = 4'b0100;
    @(negedge clk);
    chk("a_grant_p2", 64'(enq_ready), 64'(4'b0100));
    tick();
    enq_valid = 4'b0000;
    @(negedge clk);
    chk("a_idle_ready", 64'(enq_ready), 64'(0));
    tick();
    chk("a_occ", 64'(occupancy), 64'(2));
    chk("a_insert_pulses", 64'(ins_cnt - base_ins), 64'(2));

    rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", 64'(occupancy), 64'(0));
    tick();
    rst_n = 1'b1;

    // All ports valid for 8 cycles: grant rotates 0,1,2,3,0,1,2,3.
    for (int k = 0; k < NP; k++) set_port(k, 10'(40 + k), 20'(20'h40000 + k));
    enq_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      sb_ins.push_back({10'(40 + i % 4), 20'(20'h40000 + i % 4)});
      @(negedge clk);
      chk($sformatf("b_grant%0d", i), 64'(enq_ready), 64'(1 << (i % 4)));
      tick();
    end
    enq_valid = 4'b0000;
    chk("b_occ8", 64'(occupancy), 64'(8));
    @(negedge clk);
    tick();

    // Dequeue and port 0 in the same cycle: remove wins, insert one cycle later.
    set_port(0, 10'd7, 20'h70707);
    enq_valid = 4'b0001;
    deq_req = 1'b1;
    pifo_valid_out = 1'b1;
    pifo_rank_out = 10'd5;
    pifo_meta_out = 20'h55555;
    sb_deq.push_back({10'd5, 20'h55555});
    @(negedge clk);
    chk("d_ready_blocked", 64'(enq_ready), 64'(0));
    tick();
    deq_req = 1'b0;
    sb_ins.push_back({10'd7, 20'h70707});
    chk("d_occ_after_remove", 64'(occupancy), 64'(7));
    @(negedge clk);
    chk("d_ready_in_remove", 64'(enq_ready), 64'(4'b0001));
    chk("d_deq_rank", 64'(deq_rank), 64'(5));
    chk("d_no_insert_with_remove", 64'(pifo_insert), 64'(0));
    tick();
    enq_valid = 4'b0000;
    base_emp = emp_cnt;
    base_rem = rem_cnt;
    deq_req = 1'b1;
    chk("d_occ_after_insert", 64'(occupancy), 64'(8));
    @(negedge clk);
    chk("d_settle_no_remove", 64'(pifo_remove), 64'(0));
    tick();
    @(negedge clk);
    chk("d_settle_no_empty", 64'(deq_empty), 64'(0));
    tick();
    deq_req = 1'b0;
    @(negedge clk);
    chk("d_settle_req_ignored", 64'(deq_empty), 64'(0));
    tick();
    chk("d_ignored_empty_cnt", 64'(emp_cnt - base_emp), 64'(0));
    chk("d_ignored_remove_cnt", 64'(rem_cnt - base_rem), 64'(0));
    chk("d_occ_hold", 64'(occupancy), 64'(8));

    // Fill to capacity with port 1, then check backpressure and saturation.
    for (int i = 0; i < 24; i++) begin
      set_port(1, 10'(100 + i), 20'(20'h01000 + i));
      enq_valid = 4'b0010;
      sb_ins.push_back({10'(100 + i), 20'(20'h01000 + i)});
      @(negedge clk);
      chk($sformatf("e_fill%0d", i), 64'(enq_ready), 64'(4'b0010));
      tick();
    end
    chk("e_occ_full", 64'(occupancy), 64'(32));
    set_port(1, 10'd999, 20'hABCDE);
    sb_ins.push_back({10'd999, 20'hABCDE});
    @(negedge clk);
    chk("e_full_ready", 64'(enq_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("e_full_ready_hold", 64'(enq_ready), 64'(0));
    chk("e_occ_saturate", 64'(occupancy), 64'(32));
    tick();
    deq_req = 1'b1;
    pifo_rank_out = 10'd3;
    pifo_meta_out = 20'h33333;
    sb_deq.push_back({10'd3, 20'h33333});
    @(negedge clk);
    chk("e_ready_full_remove", 64'(enq_ready), 64'(0));
    tick();
    deq_req = 1'b0;
    pifo_busy = 1'b1;
    chk("e_occ31", 64'(occupancy), 64'(31));
    @(negedge clk);
    chk("e_busy_remove", 64'(enq_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("e_busy_settle1", 64'(enq_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("e_busy_settle2", 64'(enq_ready), 64'(0));
    tick();
    pifo_busy = 1'b0;
    @(negedge clk);
    chk("e_ready_after_settle", 64'(enq_ready), 64'(4'b0010));
    tick();
    enq_valid = 4'b0000;
    chk("e_occ_refill", 64'(occupancy), 64'(32));
    @(negedge clk);

    // Reset while in SETTLE.
    tick();
    deq_req = 1'b1;
    pifo_rank_out = 10'd4;
    pifo_meta_out = 20'h44444;
    sb_deq.push_back({10'd4, 20'h44444});
    tick();
    deq_req = 1'b0;
    enq_valid = 4'b1111;
    pifo_busy = 1'b1;
    @(negedge clk);
    tick();
    #2;
    rst_n = 1'b0;
    pifo_busy = 1'b0;
    #1;
    chk_reset_outs("f_rst");
    tick();
    rst_n = 1'b1;
    enq_valid = 4'b0000;
    pifo_valid_out = 1'b0;
    base_ins = ins_cnt;
    base_rem = rem_cnt;
    base_emp = emp_cnt;
    repeat (5) tick();
    chk("f_no_insert", 64'(ins_cnt - base_ins), 64'(0));
    chk("f_no_remove", 64'(rem_cnt - base_rem), 64'(0));
    chk("f_no_empty", 64'(emp_cnt - base_emp), 64'(0));
    chk("f_occ", 64'(occupancy), 64'(0));

    chk("sb_ins_drained", 64'(sb_ins.size()), 64'(0));
    chk("sb_deq_drained", 64'(sb_deq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pifo_req_sched.md
PIFO_REQ_SCHED -- requirements
Module: pifo_req_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of enqueue requesters.
REQ-002 SHALL have parameter RANK_WIDTH, default 10, rank width.
REQ-003 SHALL have parameter META_WIDTH, default 20, metadata width.
REQ-004 SHALL have parameter MAX_ENTRIES, default 32, PIFO capacity.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 2, post-remove idle cycles (1..15).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port enq_valid  in  NUM_PORTS  per-port insert request.
REQ-009 SHALL have port enq_ready  out  NUM_PORTS  per-port accept.
REQ-010 SHALL have port enq_rank  in  NUM_PORTS*RANK_WIDTH  packed ranks, port k at [k*RANK_WIDTH +: RANK_WIDTH].
REQ-011 SHALL have port enq_meta  in  NUM_PORTS*META_WIDTH  packed metadata, same packing.
REQ-012 SHALL have port deq_req  in  1  one-cycle dequeue request.
REQ-013 SHALL have ports deq_valid / deq_rank / deq_meta  out  1 / RANK_WIDTH / META_WIDTH  dequeued entry.
REQ-014 SHALL have port deq_empty  out  1  dequeue refused.
REQ-015 SHALL have ports pifo_insert / pifo_rank_in / pifo_meta_in  out  1 / RANK_WIDTH / META_WIDTH  PIFO insert side.
REQ-016 SHALL have ports pifo_remove  out  1, pifo_busy  in  1, pifo_valid_out  in  1, pifo_rank_out  in  RANK_WIDTH, pifo_meta_out  in  META_WIDTH.
REQ-017 SHALL have port occupancy  out  $clog2(MAX_ENTRIES)+1  entries held.

Function
REQ-018 can_insert = ~pifo_busy & (occupancy < MAX_ENTRIES) & ~remove_now; remove_now = dequeue FSM in IDLE & deq_req & pifo_valid_out & (occupancy != 0).
REQ-019 Round-robin grant: first valid port at or after rr_ptr (wrapping); enq_ready[k] = can_insert & grant==k; at most one bit high; combinational.
REQ-020 Accept = enq_valid[k] & enq_ready[k]; rr_ptr <= k+1 mod NUM_PORTS on accept, else unchanged.
REQ-021 Accepted rank/meta SHALL appear on pifo_rank_in/pifo_meta_in with pifo_insert high exactly one cycle, cycle after accept (1-cycle latency); zero otherwise.
REQ-022 Dequeue FSM IDLE -> REMOVE -> SETTLE -> IDLE; REMOVE lasts 1 cycle, SETTLE lasts SETTLE_CYCLES cycles.
REQ-023 IDLE & remove_now: register pifo_rank_out/pifo_meta_out to deq_rank/deq_meta, go REMOVE; in REMOVE, deq_valid=1 and pifo_remove=1 for that single cycle.
REQ-024 IDLE & deq_req & ~remove_now: deq_empty pulses 1 cycle later; state stays IDLE.
REQ-025 deq_req outside IDLE SHALL be ignored (no deq_empty, no remove).
REQ-026 pifo_insert and pifo_remove SHALL never be high in the same cycle; remove has priority (insert acceptance blocked on remove_now).
REQ-027 occupancy +1 on accept, -1 on remove_now, unchanged on neither; saturates at 0 and MAX_ENTRIES (never wraps).
REQ-028 At occupancy==MAX_ENTRIES all enq_ready low; requests stay pending, never dropped.

Reset
REQ-029 rst_n low SHALL immediately clear: enq_ready combinational 0, pifo_insert/remove 0, deq_valid/deq_empty 0, deq_rank/meta 0, pifo_rank_in/meta_in 0, occupancy 0, rr_ptr 0, FSM IDLE.
REQ-030 Reset mid-REMOVE/SETTLE SHALL abort to IDLE; no pulse emitted after rst_n rises until new request.

Structure
REQ-031 FSM state encoding and default widths SHALL live in shared package pifo_pkg.
REQ-032 Round-robin grant SHALL be sub-module rr_arbiter (NUM_PORTS req, ptr -> one-hot grant).

Verification
REQ-033 Ports 0,2 valid, rr_ptr 0, busy 0 -> port 0 accepted cycle 1, port 2 cycle 2, pifo_insert pulses cycles 2,3.
REQ-034 All 4 ports valid continuously, 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; occupancy 8.
REQ-035 occupancy 32, port 1 valid -> enq_ready 0; deq_req with pifo_valid_out -> remove pulse, occupancy 31, port 1 accepted after SETTLE.
REQ-036 deq_req and port 0 valid same cycle, rank 5 at PIFO head -> deq_valid rank 5, port 0 accept delayed one cycle, no simultaneous insert/remove.
REQ-037 deq_req with occupancy 0 -> deq_empty one cycle, no pifo_remove.
REQ-038 rst_n low during SETTLE -> all outputs 0 asynchronously, FSM IDLE, occupancy 0.
